// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 10-bit computer.
// Each instruction is sequenced through FETCH, DECODE, EXEC, (MEM), WB. The
// instruction is held in an internal IR. Instruction and data memory are
// accessed through request/acknowledge handshakes.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   start             leave IDLE (sampled in IDLE only)
//   instr/instr_valid instruction word and its valid (sampled in FETCH only)
//   mem_ack           data memory completion (sampled in MEM only)
//   imem_req          instruction fetch request (FETCH)
//   mem_req, ldst_en  data memory request / address path enable (MEM)
//   mem_we            data memory write for stores (MEM)
//   alu_op            ALU function
//   writeval_op       write mux: 0 ALU, 1 PC+1, 2 immediate, 3 register copy
//   wr_en, wr_reg     register-file write strobe and index
//   read_reg1/2       IR[5:3], IR[2:0]
//   imm_val           sign-extended IR[7:0]
//   jmp_addr          sign-extended IR[5:0]
//   pc_en, fetch_op   PC update strobe and source select
//   busy, done        activity / halted status
//   retired           saturating count of completed instructions
module multicycle_control_unit #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        instr,
    input  logic              instr_valid,
    input  logic              mem_ack,
    output logic              imem_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ldst_en,
    output logic [1:0]        alu_op,
    output logic [1:0]        writeval_op,
    output logic              wr_en,
    output logic [2:0]        wr_reg,
    output logic [2:0]        read_reg1,
    output logic [2:0]        read_reg2,
    output logic [DATA_W-1:0] imm_val,
    output logic [ADDR_W-1:0] jmp_addr,
    output logic              pc_en,
    output logic [1:0]        fetch_op,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state, state_next;
    logic [9:0]       ir;
    logic [CNT_W-1:0] retired_cnt;

    logic [1:0] op_class, op_sub;
    logic       is_mem, is_store, is_halt, writes_reg;
    logic [1:0] dec_alu, dec_wval, dec_fetch;
    logic [2:0] dec_wreg;
    logic       field_window;

    assign op_class = ir[9:8];
    assign op_sub   = ir[7:6];
    assign retired  = retired_cnt;

    // Instruction decode from IR; fields that carry no meaning stay at 0.
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_halt    = 1'b0;
        writes_reg = 1'b0;
        dec_alu    = 2'd0;
        dec_wval   = 2'd0;
        dec_fetch  = 2'd0;
        dec_wreg   = 3'd0;
        case (op_class)
            2'd0: begin
                dec_alu    = op_sub;
                writes_reg = 1'b1;
                dec_wreg   = 3'd4;
            end
            2'd1: begin
                case (op_sub)
                    2'd0: begin
                        writes_reg = 1'b1;
                        dec_wreg   = ir[5:3];
                        dec_wval   = 2'd3;
                    end
                    2'd1: begin
                        is_mem     = 1'b1;
                        writes_reg = 1'b1;
                        dec_wreg   = 3'd5;
                    end
                    2'd2: begin
                        is_mem   = 1'b1;
                        is_store = 1'b1;
                    end
                    default: dec_fetch = 2'd2;
                endcase
            end
            2'd2: begin
                writes_reg = 1'b1;
                dec_wreg   = 3'd5;
                dec_wval   = 2'd2;
            end
            default: begin
                case (op_sub)
                    2'd2: begin
                        dec_fetch  = 2'd1;
                        writes_reg = 1'b1;
                        dec_wreg   = 3'd6;
                        dec_wval   = 2'd1;
                    end
                    2'd3: begin
                        dec_fetch = 2'd3;
                        is_halt   = 1'b1;
                    end
                    default: dec_fetch = 2'd1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && instr_valid) begin
                ir <= instr;
            end
            if (state == S_WB && retired_cnt != '1) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = is_mem ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) state_next = S_WB;
            S_WB:     state_next = is_halt ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Field outputs are only driven while an instruction is in flight, so
    // IDLE, FETCH and HALT present all-zero controls.
    assign field_window = (state == S_DECODE) || (state == S_EXEC) ||
                          (state == S_MEM)    || (state == S_WB);

    always_comb begin
        imem_req    = (state == S_FETCH);
        mem_req     = (state == S_MEM);
        ldst_en     = (state == S_MEM);
        mem_we      = (state == S_MEM) && is_store;
        wr_en       = (state == S_WB) && writes_reg;
        pc_en       = (state == S_WB);
        busy        = (state != S_IDLE) && (state != S_HALT);
        done        = (state == S_HALT);
        alu_op      = 2'd0;
        writeval_op = 2'd0;
        wr_reg      = 3'd0;
        fetch_op    = 2'd0;
        read_reg1   = 3'd0;
        read_reg2   = 3'd0;
        imm_val     = '0;
        jmp_addr    = '0;
        if (field_window) begin
            alu_op        = dec_alu;
            writeval_op   = dec_wval;
            wr_reg        = dec_wreg;
            fetch_op      = dec_fetch;
            read_reg1     = ir[5:3];
            read_reg2     = ir[2:0];
            imm_val       = {DATA_W{ir[7]}};
            imm_val[7:0]  = ir[7:0];
            jmp_addr      = {ADDR_W{ir[5]}};
            jmp_addr[5:0] = ir[5:0];
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst, start, instr_valid, mem_ack;
    logic [9:0]        instr;
    logic              imem_req, mem_req, mem_we, ldst_en, wr_en, pc_en, busy, done;
    logic [1:0]        alu_op, writeval_op, fetch_op;
    logic [2:0]        wr_reg, read_reg1, read_reg2;
    logic [DATA_W-1:0] imm_val;
    logic [ADDR_W-1:0] jmp_addr;
    logic [CNT_W-1:0]  retired;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .instr_valid(instr_valid),
        .mem_ack(mem_ack), .imem_req(imem_req), .mem_req(mem_req), .mem_we(mem_we),
        .ldst_en(ldst_en), .alu_op(alu_op), .writeval_op(writeval_op), .wr_en(wr_en),
        .wr_reg(wr_reg), .read_reg1(read_reg1), .read_reg2(read_reg2), .imm_val(imm_val),
        .jmp_addr(jmp_addr), .pc_en(pc_en), .fetch_op(fetch_op), .busy(busy), .done(done),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference model: expected behaviour of one instruction from the opcode table.
    typedef struct {
        bit mem; bit store; bit writes; bit halt;
        int wreg; int wv; int fop; int alu;
    } exp_t;

    function automatic exp_t model(input int ins);
        int cls = ins / 256;
        int sub = (ins / 64) % 4;
        exp_t e = '{default: 0};
        if (cls == 0) begin
            e.alu = sub; e.writes = 1; e.wreg = 4;
        end else if (cls == 1) begin
            if (sub == 0) begin e.writes = 1; e.wreg = (ins / 8) % 8; e.wv = 3; end
            else if (sub == 1) begin e.mem = 1; e.writes = 1; e.wreg = 5; end
            else if (sub == 2) begin e.mem = 1; e.store = 1; end
            else e.fop = 2;
        end else if (cls == 2) begin
            e.writes = 1; e.wreg = 5; e.wv = 2;
        end else begin
            if (sub == 2) begin e.fop = 1; e.writes = 1; e.wreg = 6; e.wv = 1; end
            else if (sub == 3) begin e.fop = 3; e.halt = 1; end
            else e.fop = 1;
        end
        return e;
    endfunction

    function automatic int sext(input int value, input int from_bits, input int to_bits);
        int v = value % (1 << from_bits);
        if (v >= (1 << (from_bits - 1))) v -= (1 << from_bits);
        return v & ((1 << to_bits) - 1);
    endfunction

    // Inputs are driven and outputs sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reset, then start: leaves the DUT in its first FETCH cycle.
    task automatic begin_run();
        rst = 1'b1; start = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; instr_valid = 1'b1; mem_ack = 1'b1; instr = 10'h3FF;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
        checks++; if (retired !== 2'd0) begin failures++; $display("FAIL reset_retired got=%0h exp=0", retired); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0h exp=0", imem_req); end
        checks++; if ({mem_req, ldst_en, mem_we, wr_en, pc_en} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%0b exp=0", {mem_req, ldst_en, mem_we, wr_en, pc_en}); end
        checks++; if ({alu_op, writeval_op, wr_reg, fetch_op, read_reg1, read_reg2} !== 15'b0) begin failures++; $display("FAIL reset_fields got=%0h exp=0", {alu_op, writeval_op, wr_reg, fetch_op, read_reg1, read_reg2}); end
        checks++; if ({imm_val, jmp_addr} !== '0) begin failures++; $display("FAIL reset_imm got=%0h exp=0", {imm_val, jmp_addr}); end
        // Without start, IDLE holds even with instr_valid high.
        tick(); tick();
        checks++; if ({busy, imem_req} !== 2'b00) begin failures++; $display("FAIL idle_hold got=%0b exp=00", {busy, imem_req}); end
        instr_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_alu();
        begin_run();
        instr = 10'h0C5; instr_valid = 1'b1;
        checks++; if ({imem_req, busy} !== 2'b11) begin failures++; $display("FAIL alu_fetch got=%0b exp=11", {imem_req, busy}); end
        tick();
        instr_valid = 1'b0;
        checks++; if ({read_reg1, read_reg2} !== 6'o05) begin failures++; $display("FAIL alu_readregs got=%0o exp=05", {read_reg1, read_reg2}); end
        checks++; if ({wr_en, pc_en} !== 2'b00) begin failures++; $display("FAIL alu_decode_strobe got=%0b exp=00", {wr_en, pc_en}); end
        tick();
        checks++; if (alu_op !== 2'd3) begin failures++; $display("FAIL alu_exec_op got=%0d exp=3", alu_op); end
        tick();
        checks++; if ({wr_en, pc_en, wr_reg, alu_op, fetch_op} !== {2'b11, 3'd4, 2'd3, 2'd0}) begin failures++; $display("FAIL alu_wb got=%0b exp=%0b", {wr_en, pc_en, wr_reg, alu_op, fetch_op}, {2'b11, 3'd4, 2'd3, 2'd0}); end
        tick();
        checks++; if ({wr_en, pc_en} !== 2'b00) begin failures++; $display("FAIL alu_pulse_width got=%0b exp=00", {wr_en, pc_en}); end
        checks++; if (retired !== 2'd1) begin failures++; $display("FAIL alu_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_load_wait();
        int mem_cycles = 0;
        instr = 10'h140; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 10 && mem_req === 1'b1; k++) begin
            mem_ack = (k == 3);
            mem_cycles++;
            checks++; if ({ldst_en, mem_we, wr_en} !== 3'b100) begin failures++; $display("FAIL load_mem_ctl got=%0b exp=100", {ldst_en, mem_we, wr_en}); end
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (mem_cycles !== 4) begin failures++; $display("FAIL load_mem_cycles got=%0d exp=4", mem_cycles); end
        checks++; if ({wr_en, pc_en, wr_reg, writeval_op} !== {2'b11, 3'd5, 2'd0}) begin failures++; $display("FAIL load_wb got=%0b exp=%0b", {wr_en, pc_en, wr_reg, writeval_op}, {2'b11, 3'd5, 2'd0}); end
        tick();
        checks++; if (retired !== 2'd2) begin failures++; $display("FAIL load_retired got=%0d exp=2", retired); end
    endtask

    task automatic test_load_imm();
        instr = 10'h280; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        checks++; if (imm_val !== 16'hFF80) begin failures++; $display("FAIL li_imm got=%0h exp=ff80", imm_val); end
        checks++; if ({writeval_op, wr_reg} !== {2'd2, 3'd5}) begin failures++; $display("FAIL li_fields got=%0b exp=%0b", {writeval_op, wr_reg}, {2'd2, 3'd5}); end
        tick(); tick();
        checks++; if ({wr_en, imm_val} !== {1'b1, 16'hFF80}) begin failures++; $display("FAIL li_wb got=%0h exp=1ff80", {wr_en, imm_val}); end
        tick();
        checks++; if (retired !== 2'd3) begin failures++; $display("FAIL li_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_jal();
        instr = 10'h3A0; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        checks++; if (jmp_addr !== 12'hFE0) begin failures++; $display("FAIL jal_addr got=%0h exp=fe0", jmp_addr); end
        checks++; if ({fetch_op, wr_reg, writeval_op} !== {2'd1, 3'd6, 2'd1}) begin failures++; $display("FAIL jal_fields got=%0b exp=%0b", {fetch_op, wr_reg, writeval_op}, {2'd1, 3'd6, 2'd1}); end
        tick(); tick();
        checks++; if ({wr_en, pc_en, fetch_op} !== {2'b11, 2'd1}) begin failures++; $display("FAIL jal_wb got=%0b exp=1101", {wr_en, pc_en, fetch_op}); end
        tick();
        checks++; if (retired !== 2'd3) begin failures++; $display("FAIL jal_saturate got=%0d exp=3", retired); end
    endtask

    task automatic test_saturation();
        instr = 10'h000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (retired !== 2'd3) begin failures++; $display("FAIL sat_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_halt();
        instr = 10'h3C0; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        checks++; if (fetch_op !== 2'd3) begin failures++; $display("FAIL halt_fetch_op got=%0d exp=3", fetch_op); end
        tick(); tick();
        checks++; if ({pc_en, wr_en, fetch_op} !== {2'b10, 2'd3}) begin failures++; $display("FAIL halt_wb got=%0b exp=1011", {pc_en, wr_en, fetch_op}); end
        tick();
        checks++; if ({done, busy, pc_en} !== 3'b100) begin failures++; $display("FAIL halt_state got=%0b exp=100", {done, busy, pc_en}); end
        start = 1'b1; instr_valid = 1'b1;
        tick(); tick();
        checks++; if ({done, busy, imem_req} !== 3'b100) begin failures++; $display("FAIL halt_ignore_start got=%0b exp=100", {done, busy, imem_req}); end
        rst = 1'b1; start = 1'b0; instr_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if ({done, busy, retired, fetch_op, pc_en} !== 7'b0) begin failures++; $display("FAIL halt_reset got=%0b exp=0", {done, busy, retired, fetch_op, pc_en}); end
    endtask

    task automatic test_reset_mid_mem();
        begin_run();
        instr = 10'h000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick(); tick(); tick();
        instr = 10'h180; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0; mem_ack = 1'b0;
        tick(); tick(); tick();
        checks++; if ({mem_req, ldst_en, mem_we} !== 3'b111) begin failures++; $display("FAIL store_mem got=%0b exp=111", {mem_req, ldst_en, mem_we}); end
        rst = 1'b1;
        checks++; if (retired !== 2'd1) begin failures++; $display("FAIL mid_mem_retired_before got=%0d exp=1", retired); end
        tick();
        rst = 1'b0;
        checks++; if ({mem_req, ldst_en, mem_we, imem_req, busy} !== 5'b0) begin failures++; $display("FAIL mid_mem_reset got=%0b exp=0", {mem_req, ldst_en, mem_we, imem_req, busy}); end
        checks++; if (retired !== 2'd0) begin failures++; $display("FAIL mid_mem_retired_after got=%0d exp=0", retired); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_mem_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_random_program(input int count);
        int exp_ret = 0;
        begin_run();
        for (int n = 0; n < count; n++) begin
            int ins = $urandom_range(0, 1023);
            int fd = $urandom_range(0, 2);
            int mw = $urandom_range(0, 3);
            exp_t e;
            if (ins >= 'h3C0) ins -= 'h100;
            e = model(ins);
            for (int k = 0; k < fd; k++) begin
                instr_valid = 1'b0; instr = 10'($urandom); mem_ack = 1'($urandom);
                checks++; if ({imem_req, busy, pc_en} !== 3'b110) begin failures++; $display("FAIL rnd_fetch_wait ins=%0h got=%0b exp=110", ins, {imem_req, busy, pc_en}); end
                tick();
            end
            instr = 10'(ins); instr_valid = 1'b1; mem_ack = 1'($urandom);
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rnd_fetch ins=%0h got=%0b exp=1", ins, imem_req); end
            tick();
            instr = 10'($urandom); instr_valid = 1'($urandom); mem_ack = 1'($urandom);
            checks++; if ({read_reg1, read_reg2} !== 6'(ins % 64)) begin failures++; $display("FAIL rnd_readregs ins=%0h got=%0o exp=%0o", ins, {read_reg1, read_reg2}, ins % 64); end
            checks++; if (int'(imm_val) !== sext(ins, 8, DATA_W)) begin failures++; $display("FAIL rnd_imm ins=%0h got=%0h exp=%0h", ins, imm_val, sext(ins, 8, DATA_W)); end
            checks++; if (int'(jmp_addr) !== sext(ins, 6, ADDR_W)) begin failures++; $display("FAIL rnd_jmp ins=%0h got=%0h exp=%0h", ins, jmp_addr, sext(ins, 6, ADDR_W)); end
            checks++; if (int'(wr_reg) !== e.wreg || int'(writeval_op) !== e.wv || int'(fetch_op) !== e.fop) begin failures++; $display("FAIL rnd_decode ins=%0h got=%0d/%0d/%0d exp=%0d/%0d/%0d", ins, wr_reg, writeval_op, fetch_op, e.wreg, e.wv, e.fop); end
            tick();
            instr = 10'($urandom); instr_valid = 1'($urandom); mem_ack = 1'($urandom);
            checks++; if (int'(alu_op) !== e.alu || mem_req !== 1'b0) begin failures++; $display("FAIL rnd_exec ins=%0h got=%0d/%0b exp=%0d/0", ins, alu_op, mem_req, e.alu); end
            tick();
            if (e.mem) begin
                for (int k = 0; k <= mw; k++) begin
                    mem_ack = (k == mw); instr_valid = 1'($urandom);
                    checks++; if ({mem_req, ldst_en, mem_we, wr_en} !== {2'b11, e.store, 1'b0}) begin failures++; $display("FAIL rnd_mem ins=%0h got=%0b exp=%0b", ins, {mem_req, ldst_en, mem_we, wr_en}, {2'b11, e.store, 1'b0}); end
                    tick();
                end
            end
            mem_ack = 1'($urandom); instr_valid = 1'($urandom);
            checks++; if ({wr_en, pc_en, mem_req} !== {e.writes, 2'b10}) begin failures++; $display("FAIL rnd_wb ins=%0h got=%0b exp=%0b", ins, {wr_en, pc_en, mem_req}, {e.writes, 2'b10}); end
            tick();
            exp_ret = (exp_ret < 3) ? exp_ret + 1 : 3;
            checks++; if (int'(retired) !== exp_ret) begin failures++; $display("FAIL rnd_retired ins=%0h got=%0d exp=%0d", ins, retired, exp_ret); end
            checks++; if ({wr_en, pc_en, imem_req} !== 3'b001) begin failures++; $display("FAIL rnd_next_fetch ins=%0h got=%0b exp=001", ins, {wr_en, pc_en, imem_req}); end
        end
        instr_valid = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_load_wait();
        test_load_imm();
        test_jal();
        test_saturation();
        test_halt();
        test_reset_mid_mem();
        test_random_program(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end
endmodule
